mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide execution unit that sits directly downstream of the register file.
- Consumes the two read-port operands (Data1/Data2) and computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers.
- HI/LO feed the write-back path (MFHI/MFLO) and are written directly by MTHI/MTLO.
- One operation at a time, with a start/busy/done handshake towards the decode/control stage.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width.
- ITER_CNT_W, 6, width of the iteration counter (must hold DATA_WIDTH).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  DATA_WIDTH  rs operand (multiplicand / dividend).
- src_b  in  DATA_WIDTH  rt operand (multiplier / divisor).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wr_data  in  DATA_WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  last DIV/DIVU had src_b == 0.
- hi  out  DATA_WIDTH  HI register.
- lo  out  DATA_WIDTH  LO register.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (any time, including mid-operation): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; operation abandoned, counter cleared.
- States:
  - IDLE: start=1 latches op, |src_a|, |src_b| (signed ops) or raw values (unsigned ops), sign flags, counter=0; go to CALC; busy=1 from next cycle.
  - CALC: one iteration per cycle for exactly DATA_WIDTH cycles.
    - Multiply: shift-add into a 2*DATA_WIDTH accumulator.
    - Divide: restoring shift-subtract producing quotient and remainder.
    - Go to FIX when counter reaches DATA_WIDTH-1.
  - FIX: one cycle; sign correction applied, then hi/lo written.
    - MULT: product negated when signs differ; hi=product[63:32], lo=product[31:0].
    - DIV: quotient negated when signs differ; remainder takes the sign of the dividend; lo=quotient, hi=remainder.
    - Go to DONE.
  - DONE: done=1 and busy=0 for exactly this cycle; next state IDLE.
    - start in DONE is ignored; it is accepted only in IDLE.
- Latency: start sampled at edge N; hi/lo are valid and done=1 in the cycle after edge N+DATA_WIDTH+1, i.e. 34 cycles for the default width.
- Divide by zero (src_b==0, DIV or DIVU):
  - Same latency as a normal divide.
  - lo=32'hFFFFFFFF, hi=src_a as latched (raw, not absolute).
  - div_by_zero=1.
- div_by_zero update rules:
  - Set in FIX for a divide by zero.
  - Cleared in FIX of any other operation.
  - Holds its value otherwise.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0; no flag.
- MTHI/MTLO:
  - In IDLE or DONE, hi_we/lo_we write wr_data at the edge; both may be asserted in the same cycle.
  - Ignored while busy=1.
  - In IDLE, start=1 takes priority and hi_we/lo_we are ignored in that cycle.
- Operands: src_a/src_b/op changing after the start edge have no effect.
- hi/lo hold their previous values throughout CALC and FIX until the FIX edge.

Test Plan:
- Reset, then MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> busy=1 for 33 cycles; done pulse at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 (0xFFFFFFFD) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU 100/7 -> lo=0x0000000E, hi=0x00000002, div_by_zero=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1; a following MULTU 2x3 -> lo=6, hi=0, div_by_zero=0.
- Start MULTU 2x3, then re-pulse start with DIVU and assert hi_we=1 (wr_data=0xAAAA5555) at cycle 10 -> both ignored; result lo=6, hi=0. Then in IDLE, hi_we=1, lo_we=1, wr_data=0x5A5A5A5A -> hi=lo=0x5A5A5A5A.
- Start DIVU, assert reset_n=0 asynchronously at cycle 15 -> immediately busy=0, done=0, hi=lo=0, div_by_zero=0. After release, a new MULTU 4x4 completes normally with lo=16.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
//
// Purpose:
//   Multi-cycle multiply/divide unit fed by the register-file read ports.
//   A start pulse in IDLE latches the operands. CALC runs one shift-add
//   (multiply) or restoring shift-subtract (divide) step per cycle for
//   DATA_WIDTH cycles. FIX then applies sign correction and writes HI/LO.
//   DONE raises a one-cycle done pulse. MTHI/MTLO write HI/LO directly
//   whenever the unit is not busy.
//
// Ports:
//   clock        system clock, posedge
//   reset_n      asynchronous active-low reset
//   start        request pulse, accepted only in IDLE
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a        multiplicand / dividend
//   src_b        multiplier / divisor
//   hi_we        MTHI write enable
//   lo_we        MTLO write enable
//   wr_data      MTHI/MTLO data
//   busy         operation in progress
//   done         one-cycle completion pulse
//   div_by_zero  last divide had a zero divisor
//   hi, lo       architectural HI/LO registers
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ITER_CNT_W = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;
  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                  state;
  logic                    is_div;
  logic                    sign_a;
  logic                    sign_b;
  logic [W-1:0]            a_raw;
  logic [W-1:0]            opnd;   // multiplicand (mult) or divisor (div), magnitude
  logic [2*W-1:0]          acc;    // mult: {partial sum, multiplier}; div: {remainder, quotient}
  logic [ITER_CNT_W-1:0]   cnt;

  // Operand magnitudes; unsigned ops (op[0]=1) pass values through untouched.
  logic         signed_op;
  logic [W-1:0] abs_a;
  logic [W-1:0] abs_b;

  always_comb begin
    signed_op = ~op[0];
    abs_a     = (signed_op && src_a[W-1]) ? -src_a : src_a;
    abs_b     = (signed_op && src_b[W-1]) ? -src_b : src_b;
  end

  // One multiply step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right, carry included.
  logic [W:0]     add_sum;
  logic [2*W-1:0] acc_mul_next;

  // One restoring divide step: shift the next dividend bit into the remainder,
  // subtract the divisor if it fits, and shift the outcome into the quotient.
  // The remainder always stays below the divisor, so the difference fits in W bits.
  logic [W:0]     shifted;
  logic           ge;
  logic [W-1:0]   rem_next;
  logic [2*W-1:0] acc_div_next;

  always_comb begin
    add_sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    acc_mul_next = {add_sum, acc[W-1:1]};

    shifted      = {acc[2*W-1:W], acc[W-1]};
    ge           = (shifted >= {1'b0, opnd});
    rem_next     = ge ? (shifted[W-1:0] - opnd) : shifted[W-1:0];
    acc_div_next = {rem_next, acc[W-2:0], ge};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      a_raw       <= '0;
      opnd        <= '0;
      acc         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // start wins over MTHI/MTLO in the same cycle
            is_div <= op[1];
            sign_a <= signed_op & src_a[W-1];
            sign_b <= signed_op & src_b[W-1];
            a_raw  <= src_a;
            opnd   <= op[1] ? abs_b : abs_a;
            acc    <= {{W{1'b0}}, (op[1] ? abs_a : abs_b)};
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            if (hi_we) hi <= wr_data;
            if (lo_we) lo <= wr_data;
          end
        end

        CALC: begin
          acc <= is_div ? acc_div_next : acc_mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) state <= FIX;
        end

        FIX: begin
          if (is_div) begin
            if (opnd == '0) begin
              // HI returns the dividend as supplied, before magnitude conversion
              lo          <= {W{1'b1}};
              hi          <= a_raw;
              div_by_zero <= 1'b1;
            end else begin
              lo          <= (sign_a ^ sign_b) ? -acc[W-1:0] : acc[W-1:0];
              hi          <= sign_a ? -acc[2*W-1:W] : acc[2*W-1:W];
              div_by_zero <= 1'b0;
            end
          end else begin
            {hi, lo}    <= (sign_a ^ sign_b) ? -acc : acc;
            div_by_zero <= 1'b0;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (hi_we) hi <= wr_data;
          if (lo_we) lo <= wr_data;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard testbench for mult_div_unit
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  mult_div_unit #(.DATA_WIDTH(32), .ITER_CNT_W(6)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops one expected result for every done pulse.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Issues one operation from IDLE (called at posedge+1) and waits for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int cyc;
    int busy_cyc;
    exp_q.push_back('{hi: eh, lo: el, dbz: ed});
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clock); #1;
    // operands changing after the start edge must not matter
    start = 1'b0; op = ~o; src_a = ~a; src_b = 32'h0;
    cyc = 1; busy_cyc = 0;
    while (!done && cyc < 60) begin
      if (busy) busy_cyc++;
      @(posedge clock); #1;
      cyc++;
    end
    check("done_cycle", cyc, 34);
    check("busy_cycles", busy_cyc, 33);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    reset_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op(OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op(OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op(OP_DIV,   32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1);
    run_op(OP_MULTU, 32'd2,        32'd3,        32'h00000000, 32'h00000006, 1'b0);

    // start and MTHI while busy are both ignored
    exp_q.push_back('{hi: 32'h0, lo: 32'h6, dbz: 1'b0});
    start = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    hi_we = 1'b1; wr_data = 32'hAAAA5555;
    @(posedge clock); #1;
    start = 1'b0; hi_we = 1'b0;
    check("hi_hold_busy", hi, 32'h0);
    cyc = 0;
    while (!done && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("ignored_done_seen", {31'd0, done}, 32'd1);
    @(posedge clock); #1;
    check("no_restart", {31'd0, busy}, 32'd0);

    // MTHI + MTLO together in IDLE
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h5A5A5A5A;
    @(posedge clock); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi", hi, 32'h5A5A5A5A);
    check("mtlo", lo, 32'h5A5A5A5A);

    // signed divide by zero returns the raw dividend in HI
    run_op(OP_DIV, 32'hFFFFFFF8, 32'h0, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1);

    // asynchronous reset in the middle of a divide
    start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    run_op(OP_MULTU, 32'd4, 32'd4, 32'h00000000, 32'h00000010, 1'b0);

    repeat (2) @(posedge clock);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
